// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: default widths,
// FSM state encoding and port-owner encoding.
package mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W  = 16;
  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_MEM_LAT = 1;

  // Latency counter holds MEM_LAT-1, so 0..3 for the legal 1..4 range.
  localparam int unsigned LAT_CNT_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin selector (purely combinational).
//   req[1:0] : requests, bit 0 = fetch port, bit 1 = data port
//   last     : 1 when the data port won the previous grant
//   grant    : one-hot winner, 2'b00 when nothing is requested
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // On a tie the port that did not win last time takes the grant.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between an instruction-fetch port and a
// load/store data port. One access at a time: IDLE -> ISSUE -> (WAIT -> RESP)
// -> IDLE. All outputs are registered.
//   clk, rst                : clock, synchronous active-high reset
//   if_req/if_addr          : fetch request (always a read)
//   if_gnt/if_rvalid/if_rdata : fetch accept pulse, read-data pulse, data
//   d_req/d_we/d_addr/d_wdata : data request (d_we=1 store, 0 load)
//   d_gnt/d_rvalid/d_rdata  : data accept pulse, load-data pulse, data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory side
//   busy                    : high whenever the FSM is not in IDLE
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
    $error("mem_arbiter: MEM_LAT=%0d is outside the supported range 1..4", MEM_LAT);
  end

  state_e                 state_q, state_d;
  owner_e                 owner_q, owner_d;
  owner_e                 last_q,  last_d;
  logic                   we_q,    we_d;
  logic [ADDR_W-1:0]      addr_q,  addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [LAT_CNT_W-1:0]   cnt_q,   cnt_d;

  logic                   if_gnt_q,    if_gnt_d;
  logic                   d_gnt_q,     d_gnt_d;
  logic                   if_rvalid_q, if_rvalid_d;
  logic                   d_rvalid_q,  d_rvalid_d;
  logic [DATA_W-1:0]      if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]      d_rdata_q,   d_rdata_d;
  logic                   mem_en_q,    mem_en_d;
  logic                   mem_we_q,    mem_we_d;
  logic                   busy_q,      busy_d;

  logic [1:0]             grant;

  rr_arbiter2 u_rr (
    .req   ({d_req, if_req}),
    .last  (last_q == OWN_DATA),
    .grant (grant)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and transaction latch logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          state_d = ST_ISSUE;
          owner_d = grant[1] ? OWN_DATA : OWN_FETCH;
          last_d  = owner_d;
          if (grant[1]) begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            we_d    = 1'b0;
            addr_d  = if_addr;
          end
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = LAT_CNT_W'(MEM_LAT - 1);
        end
      end
      ST_WAIT: begin
        // WAIT lasts MEM_LAT cycles; the last one sees valid mem_rdata.
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so they can be registered.
  always_comb begin
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    busy_d      = (state_d != ST_IDLE);
    if (state_d == ST_ISSUE) begin
      mem_en_d = 1'b1;
      mem_we_d = we_d;
      if_gnt_d = (owner_d == OWN_FETCH);
      d_gnt_d  = (owner_d == OWN_DATA);
    end
    // mem_rdata is captured on the WAIT->RESP edge and presented in RESP.
    if (state_d == ST_RESP) begin
      if (owner_d == OWN_FETCH) begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = mem_rdata;
      end else begin
        d_rvalid_d  = 1'b1;
        d_rdata_d   = mem_rdata;
      end
    end
  end

  // Transaction and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= OWN_FETCH;
      last_q      <= OWN_DATA;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), each with
// its own memory. A transaction-level model predicts every output each cycle;
// directed sequences add literal expectations, then random traffic follows.
module tb_mem_arbiter;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        if_req    [2];
  logic [15:0] if_addr   [2];
  logic        if_gnt    [2];
  logic        if_rvalid [2];
  logic [15:0] if_rdata  [2];
  logic        d_req     [2];
  logic        d_we      [2];
  logic [15:0] d_addr    [2];
  logic [15:0] d_wdata   [2];
  logic        d_gnt     [2];
  logic        d_rvalid  [2];
  logic [15:0] d_rdata   [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [15:0] mem_addr  [2];
  logic [15:0] mem_wdata [2];
  logic [15:0] mem_rdata [2];
  logic        busy      [2];

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT0)) u_dut0 (
    .clk(clk), .rst(rst[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst(rst[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(input string name, input int k,
                              input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: actual=0x%0h required=0x%0h at t=%0t",
                  name, k, act, exp, $time);
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [15:0] init_word(input int a);
    logic [7:0] b;
    b = 8'(a);
    if (a == 4) return 16'h1A2B;
    return {b, ~b};
  endfunction

  // ---------------- memory environment (MEM_LAT-deep read pipe) ----------
  logic [15:0] ram  [2][256];
  logic [15:0] pipe [2][4];
  logic        ram_ready = 1'b0;

  assign mem_rdata[0] = pipe[0][LAT0-1];
  assign mem_rdata[1] = pipe[1][LAT1-1];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!ram_ready) begin
        for (int a = 0; a < 256; a++) ram[k][a] <= init_word(a);
      end else if (mem_en[k] === 1'b1 && mem_we[k] === 1'b1) begin
        ram[k][mem_addr[k][7:0]] <= mem_wdata[k];
      end
      pipe[k][0] <= (mem_en[k] === 1'b1) ? ram[k][mem_addr[k][7:0]] : 16'hDEAD;
      for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
    end
    ram_ready <= 1'b1;
  end

  // ---------------- transaction-level reference model ---------------------
  // cyc is the index of the current clock cycle. An accepted request at
  // cycle N schedules gnt/mem access at N+1; reads return at N+2+LAT and
  // free the arbiter at N+3+LAT, writes free it at N+2.
  int          cyc       = 0;
  bit          chk_en    [2] = '{1'b0, 1'b0};
  int          free_c    [2] = '{0, 0};
  int          gnt_c     [2] = '{-1, -1};
  int          rv_c      [2] = '{-1, -1};
  bit          last_isd  [2] = '{1'b1, 1'b1};
  bit          own_d     [2] = '{1'b0, 1'b0};
  bit          m_we      [2] = '{1'b0, 1'b0};
  logic [15:0] m_addr    [2];
  logic [15:0] m_wdata   [2];
  logic [15:0] rv_data   [2];
  logic [15:0] exp_if_rd [2];
  logic [15:0] exp_d_rd  [2];
  logic [15:0] ref_mem   [2][256];
  bit          ref_ready = 1'b0;

  always @(posedge clk) begin
    bit win_d;
    if (!ref_ready) begin
      for (int k = 0; k < 2; k++)
        for (int a = 0; a < 256; a++) ref_mem[k][a] = init_word(a);
      ref_ready = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      if (rst[k] === 1'b1) begin
        chk_en[k]    = 1'b1;
        free_c[k]    = cyc + 1;
        gnt_c[k]     = -1;
        rv_c[k]      = -1;
        last_isd[k]  = 1'b1;
        exp_if_rd[k] = 16'h0;
        exp_d_rd[k]  = 16'h0;
      end else if (chk_en[k] && cyc >= free_c[k] &&
                   (if_req[k] === 1'b1 || d_req[k] === 1'b1)) begin
        if (if_req[k] === 1'b1 && d_req[k] === 1'b1) win_d = !last_isd[k];
        else                                         win_d = (d_req[k] === 1'b1);
        own_d[k]    = win_d;
        last_isd[k] = win_d;
        m_we[k]     = win_d && (d_we[k] === 1'b1);
        m_addr[k]   = win_d ? d_addr[k] : if_addr[k];
        m_wdata[k]  = d_wdata[k];
        gnt_c[k]    = cyc + 1;
        if (m_we[k]) begin
          ref_mem[k][m_addr[k][7:0]] = m_wdata[k];
          rv_c[k]   = -1;
          free_c[k] = cyc + 2;
        end else begin
          rv_data[k] = ref_mem[k][m_addr[k][7:0]];
          rv_c[k]    = cyc + 2 + lat_of(k);
          free_c[k]  = cyc + 3 + lat_of(k);
        end
      end
    end
    cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (cyc == rv_c[k]) begin
        if (own_d[k]) exp_d_rd[k]  = rv_data[k];
        else          exp_if_rd[k] = rv_data[k];
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    bit e_en;
    bit e_rv;
    for (int k = 0; k < 2; k++) begin
      if (chk_en[k]) begin
        e_en = (cyc == gnt_c[k]);
        e_rv = (cyc == rv_c[k]);
        chk("if_gnt",    k, 32'(if_gnt[k]),    32'(e_en && !own_d[k]));
        chk("d_gnt",     k, 32'(d_gnt[k]),     32'(e_en &&  own_d[k]));
        chk("mem_en",    k, 32'(mem_en[k]),    32'(e_en));
        chk("mem_we",    k, 32'(mem_we[k]),    32'(e_en && m_we[k]));
        chk("busy",      k, 32'(busy[k]),      32'(cyc < free_c[k]));
        chk("if_rvalid", k, 32'(if_rvalid[k]), 32'(e_rv && !own_d[k]));
        chk("d_rvalid",  k, 32'(d_rvalid[k]),  32'(e_rv &&  own_d[k]));
        chk("if_rdata",  k, 32'(if_rdata[k]),  32'(exp_if_rd[k]));
        chk("d_rdata",   k, 32'(d_rdata[k]),   32'(exp_d_rd[k]));
        if (e_en) chk("mem_addr", k, 32'(mem_addr[k]), 32'(m_addr[k]));
        if (e_en && m_we[k]) chk("mem_wdata", k, 32'(mem_wdata[k]), 32'(m_wdata[k]));
      end
    end
  end

  // ---------------- stimulus ---------------------------------------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (busy[k] !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    chk("idle_timeout", k, 32'(busy[k]), 32'd0);
  endtask

  int seq [4];
  int ng;
  int dbl;
  bit if_pend [2];
  bit d_pend  [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = 16'h0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = 16'h0; d_wdata[k] = 16'h0;
      if_pend[k] = 1'b0; d_pend[k] = 1'b0;
    end
    repeat (3) step();

    // Reset state
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy",     k, 32'(busy[k]),     32'd0);
      chk("rst_if_gnt",   k, 32'(if_gnt[k]),   32'd0);
      chk("rst_mem_en",   k, 32'(mem_en[k]),   32'd0);
      chk("rst_mem_addr", k, 32'(mem_addr[k]), 32'd0);
      chk("rst_if_rdata", k, 32'(if_rdata[k]), 32'd0);
      chk("rst_d_rdata",  k, 32'(d_rdata[k]),  32'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Fetch read of 0x0004, MEM_LAT=1: gnt at N+1, rvalid at N+3
    if_req[0] = 1'b1; if_addr[0] = 16'h0004;
    step();
    chk("fetch_gnt",      0, 32'(if_gnt[0]),   32'd1);
    chk("fetch_mem_addr", 0, 32'(mem_addr[0]), 32'h0004);
    if_req[0] = 1'b0;
    step();
    chk("fetch_rv_early", 0, 32'(if_rvalid[0]), 32'd0);
    step();
    chk("fetch_rvalid", 0, 32'(if_rvalid[0]), 32'd1);
    chk("fetch_rdata",  0, 32'(if_rdata[0]),  32'h1A2B);

    // Store 0xBEEF to 0x0010, then load it back
    wait_idle(0);
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 16'h0010; d_wdata[0] = 16'hBEEF;
    step();
    chk("sw_gnt",      0, 32'(d_gnt[0]),    32'd1);
    chk("sw_mem_en",   0, 32'(mem_en[0]),   32'd1);
    chk("sw_mem_we",   0, 32'(mem_we[0]),   32'd1);
    chk("sw_mem_addr", 0, 32'(mem_addr[0]), 32'h0010);
    d_req[0] = 1'b0;
    step();
    chk("sw_busy_n2", 0, 32'(busy[0]), 32'd0);
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0010;
    step();
    chk("lw_gnt", 0, 32'(d_gnt[0]), 32'd1);
    d_req[0] = 1'b0;
    repeat (2) step();
    chk("lw_rvalid", 0, 32'(d_rvalid[0]), 32'd1);
    chk("lw_rdata",  0, 32'(d_rdata[0]),  32'hBEEF);

    // Both ports requesting continuously after reset: F, D, F, D
    wait_idle(0);
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    if_req[0] = 1'b1; if_addr[0] = 16'h0040;
    d_req[0]  = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0041;
    ng = 0; dbl = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      step();
      if (if_gnt[0] === 1'b1 && d_gnt[0] === 1'b1) dbl++;
      if (if_gnt[0] === 1'b1)     begin seq[ng] = 0; ng++; end
      else if (d_gnt[0] === 1'b1) begin seq[ng] = 1; ng++; end
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    chk("rr_double_gnt", 0, 32'(dbl), 32'd0);
    chk("rr_gnt_count",  0, 32'(ng),  32'd4);
    chk("rr_gnt0", 0, 32'(seq[0]), 32'd0);
    chk("rr_gnt1", 0, 32'(seq[1]), 32'd1);
    chk("rr_gnt2", 0, 32'(seq[2]), 32'd0);
    chk("rr_gnt3", 0, 32'(seq[3]), 32'd1);

    // MEM_LAT=3 load of 0x0020: d_rvalid at exactly N+5, no if_gnt while busy
    wait_idle(1);
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 16'h0020;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 1) begin
        chk("lat3_d_gnt", 1, 32'(d_gnt[1]), 32'd1);
        d_req[1] = 1'b0; if_req[1] = 1'b1; if_addr[1] = 16'h0030;
      end
      chk("lat3_d_rvalid", 1, 32'(d_rvalid[1]), 32'(i == 5));
      chk("lat3_if_gnt",   1, 32'(if_gnt[1]),   32'd0);
      if (i == 5) chk("lat3_d_rdata", 1, 32'(d_rdata[1]), 32'h20DF);
    end
    step();
    chk("lat3_if_gnt_after", 1, 32'(if_gnt[1]), 32'd1);
    if_req[1] = 1'b0;

    // Reset during WAIT of a fetch aborts it; the next tie goes to fetch
    wait_idle(0);
    if_req[0] = 1'b1; if_addr[0] = 16'h0004;
    step();
    chk("abort_gnt", 0, 32'(if_gnt[0]), 32'd1);
    if_req[0] = 1'b0;
    step();
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    chk("abort_busy",   0, 32'(busy[0]),      32'd0);
    chk("abort_rvalid", 0, 32'(if_rvalid[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_rvalid", 0, 32'(if_rvalid[0]), 32'd0);
    end
    if_req[0] = 1'b1; if_addr[0] = 16'h0008;
    d_req[0]  = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0009;
    step();
    chk("abort_tie_if_gnt", 0, 32'(if_gnt[0]), 32'd1);
    chk("abort_tie_d_gnt",  0, 32'(d_gnt[0]),  32'd0);
    if_req[0] = 1'b0; d_req[0] = 1'b0;

    // Random traffic with occasional resets
    for (int t = 0; t < 3000; t++) begin
      for (int k = 0; k < 2; k++) begin
        if (rst[k]) rst[k] = 1'b0;
        else if ($urandom_range(0, 299) == 0) rst[k] = 1'b1;
        if (if_gnt[k] === 1'b1) if_pend[k] = 1'b0;
        if (d_gnt[k] === 1'b1)  d_pend[k]  = 1'b0;
        if (!if_pend[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            if_pend[k] = 1'b1;
            if_addr[k] = 16'($urandom_range(0, 255));
          end else begin
            if_addr[k] = 16'($urandom);
          end
        end
        if (!d_pend[k]) begin
          d_we[k]    = 1'($urandom_range(0, 1));
          d_wdata[k] = 16'($urandom);
          if ($urandom_range(0, 2) == 0) begin
            d_pend[k] = 1'b1;
            d_addr[k] = 16'($urandom_range(0, 255));
          end else begin
            d_addr[k] = 16'($urandom);
          end
        end
        if_req[k] = if_pend[k];
        d_req[k]  = d_pend[k];
      end
      step();
    end

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; if_req[k] = 1'b0; d_req[k] = 1'b0;
    end
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
